// File: rtl/sqrt_result_checker.sv
// Verifies square-root unit results: recomputes root^2 with a shift-add multiplier,
// derives the remainder, flags non-floor roots, and queues {root, rem, err} in a small FIFO.
module sqrt_result_checker #(
  parameter int VALUE_WIDTH = 16,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [VALUE_WIDTH-1:0]   valor_i,
  input  logic                     ready_i,
  input  logic [VALUE_WIDTH/2-1:0] root_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [VALUE_WIDTH/2-1:0] out_root_o,
  output logic [VALUE_WIDTH-1:0]   out_rem_o,
  output logic                     out_err_o,
  output logic                     busy_o,
  output logic                     overflow_o
);

  localparam int RW = VALUE_WIDTH / 2;
  localparam int CW = (RW > 1) ? $clog2(RW) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = RW + VALUE_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_CHECK, S_PUSH} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   r_ready_q;
  logic [RW-1:0]          r_root;
  logic [VALUE_WIDTH-1:0] r_val;
  logic [VALUE_WIDTH-1:0] r_acc;
  logic [CW-1:0]          r_cnt;
  logic [VALUE_WIDTH-1:0] r_rem;
  logic                   r_err;
  logic                   r_overflow;

  logic [EW-1:0]          r_mem [FIFO_DEPTH];
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [PW:0]            r_count;

  logic                   w_event;
  logic [VALUE_WIDTH-1:0] w_partial;
  logic [VALUE_WIDTH:0]   w_diff;
  logic [VALUE_WIDTH-1:0] w_two_r;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push;
  logic [EW-1:0]          w_head;

  assign w_event   = ready_i & ~r_ready_q;
  assign w_partial = VALUE_WIDTH'(r_root) << r_cnt;
  // One extra bit so the borrow tells us V < R^2 directly.
  assign w_diff    = {1'b0, r_val} - {1'b0, r_acc};
  assign w_two_r   = VALUE_WIDTH'({r_root, 1'b0});

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (PW+1)'(FIFO_DEPTH));
  assign w_pop   = ~w_empty & out_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push  = (r_state == S_PUSH) & (~w_full | w_pop);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_event) w_state_next = S_MUL;
      S_MUL:   if (r_cnt == CW'(RW - 1)) w_state_next = S_CHECK;
      S_CHECK: w_state_next = S_PUSH;
      S_PUSH:  if (w_push) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ready_q  <= 1'b1;
      r_root     <= '0;
      r_val      <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_err      <= 1'b0;
      r_overflow <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_ready_q <= ready_i;
      if (w_event && (r_state != S_IDLE)) r_overflow <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_event) begin
            r_root <= root_i;
            r_val  <= valor_i;
            r_acc  <= '0;
            r_cnt  <= '0;
          end
        end
        S_MUL: begin
          if (r_root[r_cnt]) r_acc <= r_acc + w_partial;
          r_cnt <= r_cnt + 1'b1;
        end
        S_CHECK: begin
          r_rem <= w_diff[VALUE_WIDTH-1:0];
          r_err <= w_diff[VALUE_WIDTH] | (w_diff[VALUE_WIDTH-1:0] > w_two_r);
        end
        default: ;
      endcase
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end

  // Storage is left unreset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_root, r_rem, r_err};
  end

  assign w_head      = r_mem[r_rd_ptr];
  assign out_valid_o = ~w_empty;
  assign out_root_o  = w_empty ? '0 : w_head[EW-1 -: RW];
  assign out_rem_o   = w_empty ? '0 : w_head[VALUE_WIDTH:1];
  assign out_err_o   = w_empty ? 1'b0 : w_head[0];
  assign busy_o      = (r_state != S_IDLE);
  assign overflow_o  = r_overflow;

endmodule

// File: doc/sqrt_result_checker.md
Name: sqrt_result_checker

Overview:
- Downstream stage of the square-root unit: consumes its `ready` / `root` outputs together with the operand that produced them.
- Recomputes root² with a sequential shift-add multiplier and derives remainder = value − root².
- Flags results that are not the floor square root.
- Presents {root, remainder, error} through a small valid/ready output FIFO to the next consumer (bus interface or test harness).

Parameters:
- VALUE_WIDTH, 16, operand width; root width is VALUE_WIDTH/2.
- FIFO_DEPTH, 2, output FIFO entries; power of two, ≥ 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- valor_i  input  VALUE_WIDTH  operand currently held by the square-root unit; stable while its ready is high.
- ready_i  input  1  square-root unit `ready` output; a 0→1 transition marks a new result.
- root_i  input  VALUE_WIDTH/2  square-root unit `root` output.
- out_valid_o  output  1  FIFO head is valid.
- out_ready_i  input  1  consumer accepts the head.
- out_root_o  output  VALUE_WIDTH/2  head root.
- out_rem_o  output  VALUE_WIDTH  head remainder, value − root² modulo 2^VALUE_WIDTH.
- out_err_o  output  1  head failed the floor-sqrt check.
- busy_o  output  1  FSM not in IDLE.
- overflow_o  output  1  sticky: a result event was dropped.

Behaviour:
- Reset (`rst` = 1 at a clk edge) values:
  - FSM → IDLE; FIFO emptied.
  - out_valid_o = 0, out_root_o = 0, out_rem_o = 0, out_err_o = 0, busy_o = 0, overflow_o = 0.
  - Internal `ready_q` → 1, so a `ready_i` already high at reset release does not trigger a capture.
  - Reset mid-operation aborts the computation and discards FIFO contents.
- Event detection:
  - `ready_q` registers `ready_i` every cycle.
  - event = `ready_i` & ~`ready_q`.
- FSM states: IDLE, MUL, CHECK, PUSH.
- IDLE:
  - On event: capture `root_i` → R and `valor_i` → V; clear accumulator; bit counter = 0; go to MUL.
- MUL: one multiplier bit per cycle, LSB first.
  - If R[cnt], acc += R << cnt. Accumulator is VALUE_WIDTH bits; R² cannot overflow it.
  - After VALUE_WIDTH/2 cycles (8 by default), go to CHECK.
- CHECK, one cycle:
  - diff = {1'b0, V} − {1'b0, acc}, computed at VALUE_WIDTH+1 bits.
  - rem = diff[VALUE_WIDTH−1:0].
  - err = diff[VALUE_WIDTH] (V < R²) OR (no borrow AND rem > 2·R).
  - Go to PUSH.
- PUSH:
  - If FIFO not full: write {R, rem, err}, go to IDLE.
  - Else hold in PUSH, with the entry retained, until a pop frees space.
  - A pop and a push in the same cycle on a full FIFO are both allowed: the push succeeds.
- Events while busy (MUL / CHECK / PUSH):
  - The event is dropped and overflow_o is set to 1.
  - overflow_o clears only on reset.
  - An event in the same cycle the FSM returns from PUSH to IDLE is also dropped; events are only accepted in IDLE.
- FIFO:
  - Pop when out_valid_o & out_ready_i.
  - Outputs are driven from the head entry, registered. out_valid_o = FIFO not empty.
  - Pointers wrap modulo FIFO_DEPTH; full / empty are distinguished by an occupancy counter.
  - Outputs are held stable while out_valid_o = 1 and out_ready_i = 0.
- Latency:
  - Event sampled at edge 0 → out_valid_o = 1 after edge VALUE_WIDTH/2 + 2, i.e. 10 cycles at default, when the FIFO is empty.
  - Throughput: one result per 11 cycles maximum.
- busy_o = 1 in MUL, CHECK and PUSH.

Test Plan:
- Correct result: V = 200, root = 14, `ready_i` rises, out_ready_i = 1 → 10 cycles later out_valid_o = 1 for one cycle; root = 14, rem = 4, err = 0.
- Maximum value: V = 65535, root = 255 → rem = 510 (0x01FE), err = 0. Repeat with V = 0, root = 0 → rem = 0, err = 0.
- Root too high: V = 100, root = 11 → err = 1, rem = 65515 (0xFFEB). Root too low: V = 100, root = 9 → err = 1, rem = 19.
- Backpressure:
  - Setup: out_ready_i = 0; three events spaced 12 cycles apart (V/root = 4/2, 9/3, 16/4).
  - Expected: FIFO fills with two entries; third holds in PUSH with busy_o = 1.
  - A fourth event while held sets overflow_o = 1.
  - Releasing out_ready_i pops 2, 3, 4 in order, each with rem = 0; the fourth event is never output.
- Spurious edges:
  - `ready_i` already high at reset release → no capture.
  - `ready_i` held high for 20 cycles → exactly one result.
- Reset mid-operation: `rst` asserted during MUL (cycle 4) with one FIFO entry pending → next cycle busy_o = 0, out_valid_o = 0, overflow_o = 0; a subsequent event processes normally.
